// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one bit per clock.
// Shares the start/ready/done_tick handshake with the binary-to-BCD encoder.
module bcd2bin #(
  parameter int unsigned D = 4,
  parameter int unsigned W = 14
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [4*D-1:0] bcd,
  output logic [W-1:0]   bin,
  output logic           done_tick,
  output logic           ready,
  output logic           err_digit,
  output logic           overflow
);

  localparam int unsigned BW = 4 * D;
  localparam int unsigned CW = $clog2(BW + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [BW-1:0]   r_digits;
  logic [BW-1:0]   w_digits_nxt;
  logic [BW-1:0]   r_acc;
  logic [BW-1:0]   w_acc_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_invalid;
  logic            w_invalid_nxt;
  logic [W-1:0]    r_bin;
  logic [W-1:0]    w_bin_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic            r_ready;
  logic            w_ready_nxt;
  logic            r_err;
  logic            w_err_nxt;
  logic            r_ovf;
  logic            w_ovf_nxt;

  logic [2*BW-1:0] w_shifted;
  logic [BW-1:0]   w_digits_adj;
  logic            w_bad;
  logic [W-1:0]    w_bin_val;
  logic            w_hi_nz;

  // One reverse double-dabble step: shift right, then correct each digit >= 8.
  assign w_shifted = {r_digits, r_acc} >> 1;

  always_comb begin
    w_digits_adj = w_shifted[2*BW-1:BW];
    for (int k = 0; k < int'(D); k++) begin
      if (w_shifted[BW + 4*k +: 4] >= 4'd8) begin
        w_digits_adj[4*k +: 4] = w_shifted[BW + 4*k +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    w_bad = 1'b0;
    for (int k = 0; k < int'(D); k++) begin
      if (bcd[4*k +: 4] > 4'd9) begin
        w_bad = 1'b1;
      end
    end
  end

  // Result truncation; a wide output can never overflow.
  generate
    if (W >= BW) begin : g_wide
      assign w_bin_val = W'(r_acc);
      assign w_hi_nz   = 1'b0;
    end else begin : g_narrow
      assign w_bin_val = r_acc[W-1:0];
      assign w_hi_nz   = |r_acc[BW-1:W];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_digits  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_invalid <= 1'b0;
      r_bin     <= '0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
      r_err     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_digits  <= w_digits_nxt;
      r_acc     <= w_acc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_invalid <= w_invalid_nxt;
      r_bin     <= w_bin_nxt;
      r_done    <= w_done_nxt;
      r_ready   <= w_ready_nxt;
      r_err     <= w_err_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_digits_nxt  = r_digits;
    w_acc_nxt     = r_acc;
    w_cnt_nxt     = r_cnt;
    w_invalid_nxt = r_invalid;
    w_bin_nxt     = r_bin;
    w_done_nxt    = 1'b0;
    w_ready_nxt   = r_ready;
    w_err_nxt     = r_err;
    w_ovf_nxt     = r_ovf;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt   = S_SHIFT;
          w_digits_nxt  = bcd;
          w_acc_nxt     = '0;
          w_cnt_nxt     = '0;
          w_invalid_nxt = w_bad;
          w_ready_nxt   = 1'b0;
        end
      end
      S_SHIFT: begin
        w_digits_nxt = w_digits_adj;
        w_acc_nxt    = w_shifted[BW-1:0];
        w_cnt_nxt    = r_cnt + CW'(1);
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
        w_ready_nxt = 1'b1;
        if (r_invalid) begin
          w_bin_nxt = '0;
          w_err_nxt = 1'b1;
          w_ovf_nxt = 1'b0;
        end else begin
          w_bin_nxt = w_bin_val;
          w_err_nxt = 1'b0;
          w_ovf_nxt = w_hi_nz;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bin       = r_bin;
  assign done_tick = r_done;
  assign ready     = r_ready;
  assign err_digit = r_err;
  assign overflow  = r_ovf;

endmodule
